// File: rtl/scan_display_ctrl.sv
// scan_display_ctrl
//   Multiplexed N-digit seven-segment controller. A one-cycle load captures a
//   value either directly as hex nibbles or, in decimal mode, through an
//   iterative shift-add-3 (double-dabble) binary-to-BCD converter. A free
//   running prescaler steps the scan index across the digits; each slot can be
//   blanked globally, before the first committed value, or by leading-zero
//   suppression.
//
// Ports
//   CLK100MHZ    in   system clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   load         in   one-cycle capture request for value/dec_mode
//   value        in   DATA_W-bit unsigned value
//   dec_mode     in   1 = decimal, 0 = hex (sampled with load)
//   lz_suppress  in   blank leading zero digits (live)
//   blank        in   turn all anodes off (live)
//   busy         out  decimal conversion in progress, load ignored
//   valid        out  digit registers hold a committed value
//   seg          out  {g,f,e,d,c,b,a}, active-low
//   AN           out  anode enables, active-low, one-hot-low

module scan_display_ctrl #(
    parameter int DATA_W      = 8,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  CLK100MHZ,
    input  logic                  Reset_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
    input  logic                  dec_mode,
    input  logic                  lz_suppress,
    input  logic                  blank,
    output logic                  busy,
    output logic                  valid,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] AN
);

    // Enough BCD digits for any DATA_W-bit value: ceil(DATA_W/3) >= ceil(DATA_W*log10(2)).
    localparam int BCD_DIGITS = (DATA_W + 2) / 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int PRE_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W      = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t                 state;
    logic [DATA_W-1:0]      bin_sr;
    logic [BCD_W-1:0]       bcd_sr;
    logic [BCD_W-1:0]       bcd_adj;
    logic [CNT_W-1:0]       bit_cnt;
    logic [3:0]             digits [NUM_DIGITS];
    logic [PRE_W-1:0]       prescaler;
    logic [IDX_W-1:0]       scan_idx;
    logic [NUM_DIGITS-1:0]  zero_from;
    logic [3:0]             cur_digit;
    logic                   slot_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any BCD nibble >= 5 gets +3 so the following
    // left shift carries correctly into the next decimal digit.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load / convert / commit sequencer. Digit registers only change on a hex
    // load or at COMMIT, so the display keeps the old value during conversion.
    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            valid   <= 1'b0;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= 4'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        if (dec_mode) begin
                            bin_sr  <= value;
                            bcd_sr  <= '0;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= CONVERT;
                        end else begin
                            // Nibbles past the top of value read as zero.
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                digits[i] <= 4'(value >> (4*i));
                            end
                            valid <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    bit_cnt          <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        digits[i] <= 4'(bcd_sr >> (4*i));
                    end
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Refresh timing: one digit slot every REFRESH_DIV clocks.
    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (prescaler == PRE_W'(REFRESH_DIV - 1)) begin
            prescaler <= '0;
            if (scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // zero_from[i] is set when digit i and every digit above it are zero,
    // i.e. digit i is a leading zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (digits[NUM_DIGITS-1] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] & (digits[i] == 4'd0);
        end
        cur_digit  = digits[scan_idx];
        slot_blank = blank | ~valid |
                     (lz_suppress & (scan_idx != '0) & zero_from[scan_idx]);
    end

    // Registered pin drivers, one cycle behind the scan index.
    always_ff @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) begin
            seg <= 7'h7F;
            AN  <= '1;
        end else if (slot_blank) begin
            seg <= 7'h7F;
            AN  <= '1;
        end else begin
            seg <= seg_decode(cur_digit);
            AN  <= ~(NUM_DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb_scan_display_ctrl
//   Directed bench for scan_display_ctrl with DATA_W=8, NUM_DIGITS=4,
//   REFRESH_DIV=4. A small reference model (edge counter, expected digits,
//   segment table) predicts AN/seg for every sampled cycle.

module tb_scan_display_ctrl;

    localparam int DATA_W      = 8;
    localparam int NUM_DIGITS  = 4;
    localparam int REFRESH_DIV = 4;

    logic                  CLK100MHZ = 1'b0;
    logic                  Reset_n;
    logic                  load;
    logic [DATA_W-1:0]     value;
    logic                  dec_mode;
    logic                  lz_suppress;
    logic                  blank;
    logic                  busy;
    logic                  valid;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] AN;

    int         check_count = 0;
    int         pass_count  = 0;
    int         edge_cnt;
    logic [3:0] exp_digits [NUM_DIGITS];
    logic       exp_valid;
    int         n_cycles;

    scan_display_ctrl #(
        .DATA_W      (DATA_W),
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .Reset_n     (Reset_n),
        .load        (load),
        .value       (value),
        .dec_mode    (dec_mode),
        .lz_suppress (lz_suppress),
        .blank       (blank),
        .busy        (busy),
        .valid       (valid),
        .seg         (seg),
        .AN          (AN)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Rising edges since reset release; the scan slot follows from this.
    always @(posedge CLK100MHZ or negedge Reset_n) begin
        if (!Reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [6:0] exp_seg_of(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Predicted pins after the most recent edge, assuming inputs and model
    // state were stable across that edge.
    task automatic checkDisplay(input string tag);
        int         slot;
        logic       lead_zero;
        logic       blanked;
        logic [3:0] exp_an;
        logic [6:0] exp_sg;
        slot      = ((edge_cnt - 1) / REFRESH_DIV) % NUM_DIGITS;
        lead_zero = 1'b1;
        for (int j = slot; j < NUM_DIGITS; j++) begin
            if (exp_digits[j] != 4'd0) lead_zero = 1'b0;
        end
        blanked = blank || !exp_valid || (lz_suppress && slot > 0 && lead_zero);
        exp_an  = blanked ? 4'hF : ~(4'b0001 << slot);
        exp_sg  = blanked ? 7'h7F : exp_seg_of(exp_digits[slot]);
        checkOutput({tag, "_an"},  32'(AN),  32'(exp_an));
        checkOutput({tag, "_seg"}, 32'(seg), 32'(exp_sg));
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] v, input logic dm);
        value    = v;
        dec_mode = dm;
        load     = 1'b1;
        @(negedge CLK100MHZ);
        load     = 1'b0;
    endtask

    // Counts sampled busy cycles (bounded) while checking the held display.
    task automatic waitIdle(input string tag, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            checkDisplay(tag);
            @(negedge CLK100MHZ);
            cycles++;
        end
        checkDisplay(tag);
    endtask

    task automatic setDigits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
        exp_digits[3] = d3;
        exp_digits[2] = d2;
        exp_digits[1] = d1;
        exp_digits[0] = d0;
    endtask

    initial begin
        Reset_n     = 1'b0;
        load        = 1'b0;
        value       = '0;
        dec_mode    = 1'b0;
        lz_suppress = 1'b0;
        blank       = 1'b0;
        exp_valid   = 1'b0;
        setDigits(4'h0, 4'h0, 4'h0, 4'h0);

        // Reset state
        repeat (3) @(negedge CLK100MHZ);
        checkOutput("rst_seg",   32'(seg),   32'h7F);
        checkOutput("rst_an",    32'(AN),    32'hF);
        checkOutput("rst_busy",  32'(busy),  32'h0);
        checkOutput("rst_valid", 32'(valid), 32'h0);

        // Hex load 8'hA5 right at reset release, then one full scan frame
        Reset_n = 1'b1;
        applyStimulus(8'hA5, 1'b0);
        checkOutput("hex_valid",  32'(valid), 32'h1);
        checkOutput("hex_busy",   32'(busy),  32'h0);
        checkOutput("hex_an_lag", 32'(AN),    32'hF);
        exp_valid = 1'b1;
        setDigits(4'h0, 4'h0, 4'hA, 4'h5);
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("hex_scan");
        end

        // Leading-zero suppression on the same value
        lz_suppress = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("hex_lz");
        end
        lz_suppress = 1'b0;

        // Decimal 255: busy for 9 cycles, old digits held meanwhile
        applyStimulus(8'd255, 1'b1);
        checkOutput("dec_busy_start", 32'(busy), 32'h1);
        waitIdle("dec_hold", n_cycles);
        checkOutput("dec_busy_cycles", 32'(n_cycles), 32'd9);
        checkOutput("dec_valid", 32'(valid), 32'h1);
        setDigits(4'h0, 4'h2, 4'h5, 4'h5);
        for (int k = 0; k < 17; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("dec_255");
        end
        lz_suppress = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("dec_255_lz");
        end
        lz_suppress = 1'b0;

        // Load of 17 during a conversion must be ignored
        applyStimulus(8'd255, 1'b1);
        @(negedge CLK100MHZ);
        @(negedge CLK100MHZ);
        applyStimulus(8'd17, 1'b1);
        waitIdle("busy_load", n_cycles);
        checkOutput("busy_load_cycles", 32'(n_cycles), 32'd6);
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("busy_load_255");
        end

        // Asynchronous reset in the middle of a conversion
        applyStimulus(8'd255, 1'b1);
        repeat (3) @(negedge CLK100MHZ);
        Reset_n = 1'b0;
        #1;
        checkOutput("abort_busy",  32'(busy),  32'h0);
        checkOutput("abort_valid", 32'(valid), 32'h0);
        checkOutput("abort_an",    32'(AN),    32'hF);
        checkOutput("abort_seg",   32'(seg),   32'h7F);
        exp_valid = 1'b0;
        setDigits(4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge CLK100MHZ);
        Reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("after_abort");
            checkOutput("after_abort_busy", 32'(busy), 32'h0);
        end

        // Blanking while the scan keeps running
        applyStimulus(8'hA5, 1'b0);
        checkOutput("blank_valid",  32'(valid), 32'h1);
        checkOutput("blank_an_lag", 32'(AN),    32'hF);
        exp_valid = 1'b1;
        setDigits(4'h0, 4'h0, 4'hA, 4'h5);
        blank = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("blanked");
        end
        blank = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK100MHZ);
            checkDisplay("unblank");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
